// File: rtl/vram_scheduler.sv
// vram_scheduler
//   Arbitrates one single-port VRAM between the display line fetch and a CPU.
//   At pixel FETCH_START of each line preceding a visible line, the next
//   line's WORDS_PER_LINE words are streamed into a double-banked line
//   buffer. Fetch has strict priority; the CPU is served when no fetch words
//   are outstanding. Every transaction returns to IDLE, giving at most one
//   word per two cycles.
// Ports:
//   clk, reset                  pixel clock, async active-high reset
//   vga_line, vga_pixel         counters from the timing generator
//   mem_req/we/addr/wdata       VRAM request (held stable until mem_ack)
//   mem_rdata, mem_ack          VRAM response (ack may coincide with req)
//   cpu_req/we/addr/wdata       CPU request, held until cpu_ack
//   cpu_rdata, cpu_ack          CPU read data and one-cycle completion
//   lb_we/bank/addr/wdata       line buffer write port
//   fetch_busy                  fetch words outstanding
//   fetch_overrun               sticky: trigger arrived mid-fetch
module vram_scheduler #(
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int WORDS_PER_LINE  = 80,
  parameter int LINE_STRIDE     = 80,
  parameter int BASE_ADDR       = 0,
  parameter int FETCH_START     = 640,
  parameter int VISIBLE_LINES   = 480,
  parameter int LINES_PER_FRAME = 525
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        vga_line,
  input  logic [9:0]        vga_pixel,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              lb_we,
  output logic              lb_bank,
  output logic [6:0]        lb_addr,
  output logic [DATA_W-1:0] lb_wdata,
  output logic              fetch_busy,
  output logic              fetch_overrun
);

  typedef enum logic [1:0] {IDLE, FETCH, CPU} state_t;

  state_t              state_q, state_d;
  logic [6:0]          cnt_q, cnt_d;        // next word index to fetch
  logic [9:0]          tgt_q, tgt_d;        // target line
  logic [6:0]          idx_q, idx_d;        // word index of the fetch in flight
  logic                stale_q, stale_d;    // in-flight fetch belongs to a superseded line
  logic                busy_q, busy_d;
  logic                ovr_q, ovr_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                lb_we_q, lb_we_d;
  logic                lb_bank_q, lb_bank_d;
  logic [6:0]          lb_addr_q, lb_addr_d;
  logic [DATA_W-1:0]   lb_wdata_q, lb_wdata_d;

  logic                trig;
  logic [9:0]          trig_tgt;
  logic [31:0]         fetch_addr;

  always_comb begin
    trig     = 1'b0;
    trig_tgt = '0;
    if (vga_pixel == 10'(FETCH_START)) begin
      if (vga_line < 10'(VISIBLE_LINES - 1)) begin
        trig     = 1'b1;
        trig_tgt = vga_line + 10'd1;
      end else if (vga_line == 10'(LINES_PER_FRAME - 1)) begin
        trig     = 1'b1;
        trig_tgt = '0;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tgt_d       = tgt_q;
    idx_d       = idx_q;
    stale_d     = stale_q;
    busy_d      = busy_q;
    ovr_d       = ovr_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_ack_d   = 1'b0;
    lb_we_d     = 1'b0;
    lb_bank_d   = lb_bank_q;
    lb_addr_d   = lb_addr_q;
    lb_wdata_d  = lb_wdata_q;

    // A trigger always restarts the line; anything still in flight is stale.
    if (trig) begin
      cnt_d     = '0;
      tgt_d     = trig_tgt;
      lb_bank_d = trig_tgt[0];
      busy_d    = 1'b1;
      if (busy_q) ovr_d = 1'b1;
      if (state_q == FETCH) stale_d = 1'b1;
    end

    // Address from post-trigger values so an IDLE->FETCH issue in a restart
    // cycle already targets the new line.
    fetch_addr = 32'(BASE_ADDR) + 32'(tgt_d) * 32'(LINE_STRIDE) + 32'(cnt_d);

    case (state_q)
      IDLE: begin
        if (busy_q) begin
          state_d    = FETCH;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = fetch_addr[ADDR_W-1:0];
          idx_d      = cnt_d;
          stale_d    = 1'b0;
        end else if (cpu_req && !cpu_ack_q) begin
          // cpu_req is still high in its ack cycle; don't reissue it.
          state_d     = CPU;
          mem_req_d   = 1'b1;
          mem_we_d    = cpu_we;
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
        end
      end
      FETCH: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          stale_d   = 1'b0;
          if (!trig && !stale_q) begin
            lb_we_d    = 1'b1;
            lb_addr_d  = idx_q;
            lb_wdata_d = mem_rdata;
            cnt_d      = cnt_q + 7'd1;
            if (cnt_q + 7'd1 == 7'(WORDS_PER_LINE)) busy_d = 1'b0;
          end
        end
      end
      CPU: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          cpu_ack_d = 1'b1;
          if (!mem_we_q) cpu_rdata_d = mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tgt_q       <= '0;
      idx_q       <= '0;
      stale_q     <= 1'b0;
      busy_q      <= 1'b0;
      ovr_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      lb_we_q     <= 1'b0;
      lb_bank_q   <= 1'b0;
      lb_addr_q   <= '0;
      lb_wdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tgt_q       <= tgt_d;
      idx_q       <= idx_d;
      stale_q     <= stale_d;
      busy_q      <= busy_d;
      ovr_q       <= ovr_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      lb_we_q     <= lb_we_d;
      lb_bank_q   <= lb_bank_d;
      lb_addr_q   <= lb_addr_d;
      lb_wdata_q  <= lb_wdata_d;
    end
  end

  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign cpu_rdata     = cpu_rdata_q;
  assign cpu_ack       = cpu_ack_q;
  assign lb_we         = lb_we_q;
  assign lb_bank       = lb_bank_q;
  assign lb_addr       = lb_addr_q;
  assign lb_wdata      = lb_wdata_q;
  assign fetch_busy    = busy_q;
  assign fetch_overrun = ovr_q;

endmodule

// File: tb/tb_vram_scheduler.sv
// Scoreboard bench for vram_scheduler: stimulus pushes expected line-buffer
// writes and CPU completions into queues; a negedge monitor pops/compares.
// VRAM model returns rdata = addr ^ 16'hA5A5.
module tb_vram_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  vga_line, vga_pixel;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        lb_we, lb_bank;
  logic [6:0]  lb_addr;
  logic [15:0] lb_wdata;
  logic        fetch_busy, fetch_overrun;

  typedef struct packed {
    logic        bank;
    logic [6:0]  addr;
    logic [15:0] data;
  } lb_exp_t;

  lb_exp_t     lb_q[$];
  logic [15:0] cpu_q[$];
  int          checks = 0;
  int          errors = 0;
  int          lb_seen = 0;
  logic        prev_cpu_memack = 1'b0;

  always #5 clk = ~clk;

  assign mem_rdata = mem_addr ^ 16'hA5A5;

  vram_scheduler dut (
    .clk(clk), .reset(reset), .vga_line(vga_line), .vga_pixel(vga_pixel),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .lb_we(lb_we), .lb_bank(lb_bank), .lb_addr(lb_addr), .lb_wdata(lb_wdata),
    .fetch_busy(fetch_busy), .fetch_overrun(fetch_overrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_data(input int a);
    return 16'(a) ^ 16'hA5A5;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_line(input int tgt);
    for (int i = 0; i < 80; i++) begin
      lb_exp_t e;
      e.bank = 1'(tgt & 1);
      e.addr = 7'(i);
      e.data = exp_data(tgt * 80 + i);
      lb_q.push_back(e);
    end
  endtask

  task automatic trigger(input int line);
    vga_line  = 10'(line);
    vga_pixel = 10'd640;
    tick();
    vga_pixel = 10'd0;
  endtask

  // Cycles from the trigger edge until fetch_busy falls (bounded).
  task automatic wait_busy_fall(output int n);
    n = 0;
    while (fetch_busy && n < 400) begin
      tick();
      n++;
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (lb_we) begin
        lb_seen++;
        if (lb_q.size() == 0) chk("lb_we_unexpected", 32'(lb_addr), 32'hFFFF_FFFF);
        else begin
          lb_exp_t e;
          e = lb_q.pop_front();
          chk("lb_entry", 32'({lb_bank, lb_addr, lb_wdata}), 32'(e));
        end
      end
      if (cpu_ack) begin
        chk("cpu_ack_after_memack", 32'(prev_cpu_memack), 32'd1);
        if (cpu_q.size() == 0) chk("cpu_ack_unexpected", 32'(cpu_rdata), 32'hFFFF_FFFF);
        else chk("cpu_rdata", 32'(cpu_rdata), 32'(cpu_q.pop_front()));
      end
    end
    prev_cpu_memack = mem_req && mem_ack && !fetch_busy;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int cnt;
    reset = 1'b1; vga_line = '0; vga_pixel = '0; mem_ack = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    tick(); tick();
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_lb", 32'({lb_we, lb_bank, lb_addr, lb_wdata}), 0);
    chk("rst_flags", 32'({fetch_busy, fetch_overrun, cpu_ack}), 0);
    reset = 1'b0;
    tick();

    // 1: line 0 -> target 1, bank 1, addresses 80..159
    mem_ack = 1'b1;
    push_line(1);
    cnt = lb_seen;
    trigger(0);
    chk("busy_after_trigger", 32'(fetch_busy), 1);
    wait_busy_fall(n);
    chk("busy_fall_cycles", n, 160);
    tick(); tick();
    chk("line1_words", lb_seen - cnt, 80);
    chk("line1_q_empty", lb_q.size(), 0);
    chk("no_overrun", 32'(fetch_overrun), 0);

    // 2: last frame line wraps to target 0; line 479 does not trigger
    push_line(0);
    trigger(524);
    wait_busy_fall(n);
    chk("wrap_busy_fall", n, 160);
    tick(); tick();
    chk("wrap_q_empty", lb_q.size(), 0);
    trigger(479);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req || fetch_busy) cnt++;
      tick();
    end
    chk("line479_no_req", cnt, 0);

    // 3: CPU read during fetch waits for the whole line
    push_line(2);
    trigger(1);
    repeat (5) tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
    cpu_q.push_back(16'hB791);
    n = 0;
    while (!cpu_ack && n < 400) begin tick(); n++; end
    chk("cpu_read_acked", 32'(cpu_ack), 1);
    chk("fetch_before_cpu", lb_q.size(), 0);
    cpu_req = 1'b0;
    repeat (4) tick();
    chk("cpu_read_q_empty", cpu_q.size(), 0);

    // 4: stalled fetch then next trigger -> overrun, stale word dropped
    mem_ack = 1'b0;
    trigger(10);
    repeat (50) tick();
    chk("stall_req", 32'(mem_req), 1);
    chk("stall_addr", 32'(mem_addr), 880);
    push_line(12);
    trigger(11);
    chk("overrun_set", 32'(fetch_overrun), 1);
    mem_ack = 1'b1;
    wait_busy_fall(n);
    tick(); tick();
    chk("overrun_q_empty", lb_q.size(), 0);
    chk("overrun_sticky", 32'(fetch_overrun), 1);

    // 5: CPU write with delayed ack keeps fields stable
    mem_ack = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 16'hBEEF;
    cpu_q.push_back(16'hB791);
    n = 0;
    while (!mem_req && n < 20) begin tick(); n++; end
    for (int k = 0; k < 4; k++) begin
      chk("wr_stable", 32'({mem_req, mem_we, mem_addr, mem_wdata[14:0]}),
          32'({1'b1, 1'b1, 16'h0010, 15'h3EEF}));
      if (k == 3) mem_ack = 1'b1;
      tick();
    end
    mem_ack = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0;
    repeat (3) tick();
    chk("cpu_write_q_empty", cpu_q.size(), 0);

    // 6: reset during a pending fetch
    trigger(20);
    n = 0;
    while (!mem_req && n < 20) begin tick(); n++; end
    chk("pre_reset_req", 32'(mem_req), 1);
    reset = 1'b1;
    #1;
    chk("async_reset_outs", 32'({mem_req, mem_addr, fetch_busy, lb_we}), 0);
    tick();
    reset = 1'b0;
    mem_ack = 1'b1;
    cnt = lb_seen;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (mem_req) n++;
      tick();
    end
    chk("post_reset_no_lb", lb_seen - cnt, 0);
    chk("post_reset_no_req", n, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_scheduler.md
Name: vram_scheduler

Overview:
- Shares one single-port VRAM between the display scanline fetch and a CPU requester.
- Reads the pixel/line counters from the VGA timing generator. At each fetch point it streams the next visible line's words into a double-banked line buffer.
- CPU gets the memory whenever no fetch words are outstanding. Sits between the timing generator, VRAM and the pixel output stage.

Parameters:
- ADDR_W, 16, VRAM word address width
- DATA_W, 16, VRAM word width
- WORDS_PER_LINE, 80, words fetched per visible line
- LINE_STRIDE, 80, word address distance between consecutive lines
- BASE_ADDR, 0, word address of line 0
- FETCH_START, 640, pixel count at which the next line's fetch is triggered
- VISIBLE_LINES, 480, visible lines per frame
- LINES_PER_FRAME, 525, total lines per frame

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- vga_line  in  10  current line from timing generator
- vga_pixel  in  10  current pixel from timing generator
- mem_req  out  1  VRAM request
- mem_we  out  1  VRAM write enable (CPU writes only)
- mem_addr  out  ADDR_W  VRAM word address
- mem_wdata  out  DATA_W  VRAM write data
- mem_rdata  in  DATA_W  VRAM read data, valid in the mem_ack cycle
- mem_ack  in  1  VRAM completion, may be high in the same cycle as mem_req
- cpu_req  in  1  CPU request, held with fields stable until cpu_ack
- cpu_we  in  1  CPU write
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  CPU read data
- cpu_ack  out  1  one-cycle CPU completion pulse
- lb_we  out  1  line buffer write strobe
- lb_bank  out  1  line buffer bank written (target line bit 0)
- lb_addr  out  7  word index within line
- lb_wdata  out  DATA_W  line buffer write data
- fetch_busy  out  1  fetch words outstanding
- fetch_overrun  out  1  sticky: trigger arrived before previous fetch finished

Behaviour:
- Reset: state IDLE. mem_req, mem_we, cpu_ack, lb_we, fetch_busy and fetch_overrun are 0. mem_addr, mem_wdata, cpu_rdata, lb_addr, lb_wdata and lb_bank are 0. A pending CPU request is dropped, and the CPU must keep or re-assert cpu_req. Reset mid-transaction abandons it with no ack.
- Trigger: any cycle with vga_pixel==FETCH_START and either vga_line < VISIBLE_LINES-1 (target = vga_line+1) or vga_line == LINES_PER_FRAME-1 (target = 0). No trigger on other lines.
- On trigger: word counter=0, target latched, lb_bank=target[0], fetch_busy=1 from the next cycle.
- Fetch address = BASE_ADDR + target*LINE_STRIDE + word index, truncated to ADDR_W.
- States:
  - IDLE → FETCH if fetch_busy; else → CPU if cpu_req; else stay. Fetch has strict priority.
  - FETCH: mem_req=1, mem_we=0, address held. On mem_ack → IDLE and word counter +1. When the counter reaches WORDS_PER_LINE, fetch_busy=0.
  - CPU: mem_req=1, mem_we=cpu_we, mem_addr=cpu_addr, mem_wdata=cpu_wdata. On mem_ack → IDLE.
- Every transaction passes through IDLE, so throughput is at most 1 word per 2 cycles. Transactions are non-preemptive: mem_req stays high with stable fields until mem_ack.
- Line buffer write: the cycle after a FETCH ack, lb_we=1 for one cycle with lb_addr = word index and lb_wdata = captured mem_rdata.
- CPU completion: the cycle after a CPU ack, cpu_ack=1 for one cycle. cpu_rdata = captured mem_rdata and holds until the next CPU read ack. CPU writes leave cpu_rdata unchanged.
- Overrun: trigger while fetch_busy=1 sets fetch_overrun (sticky until reset). Counter and target restart for the new line. A FETCH transaction in flight completes, but its lb_we is suppressed.
- Trigger during a CPU transaction: the CPU transaction completes normally, then FETCH starts from the next IDLE.
- Trigger in the same cycle as a FETCH ack: the restart wins, and that ack's write is suppressed.

Test Plan:
- mem_ack tied 1, no CPU, run line 0 to pixel 640 → 80 lb_we pulses on bank 1, lb_addr 0..79, mem_addr 80..159. fetch_busy falls 160 cycles after trigger, fetch_overrun=0.
- Line 524 pixel 640 → target 0, bank 0, mem_addr 0..79. Line 479 pixel 640 → no mem_req.
- cpu_req read addr 0x1234 during a fetch with mem_ack=1 → all fetch words issued first; cpu_ack exactly one cycle after the CPU mem_ack, cpu_rdata = mem_rdata.
- mem_ack held 0 for an entire line → next trigger sets fetch_overrun=1, no lb_we for the stalled word, new fetch uses new target.
- CPU write 0xBEEF to 0x0010, mem_ack delayed 3 cycles → mem_req/mem_we/addr/wdata stable 4 cycles, one cpu_ack, cpu_rdata unchanged.
- Assert reset while FETCH waits for ack → all outputs 0 immediately; after release, no lb_we until the next trigger.
